// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 interrupt-acknowledge path.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK1,
    ST_GAP,
    ST_ACK2
  } state_e;

  localparam int DEF_NUM_IR      = 8;
  localparam int DEF_SPURIOUS_IR = 7;
  localparam int VEC_LO_W        = 3;

endpackage

// File: rtl/pic_priority_encoder.sv
// Fixed-priority encoder: lowest-index set bit wins (IR0 highest).
module pic_priority_encoder
  import pic_pkg::*;
(
  input  logic [DEF_NUM_IR-1:0] vec_i,
  output logic [VEC_LO_W-1:0]   idx_o,
  output logic                  valid_o,
  output logic [DEF_NUM_IR-1:0] onehot_o
);

  always_comb begin
    idx_o = '0;
    for (int i = DEF_NUM_IR - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = VEC_LO_W'(i);
    end
  end

  assign valid_o  = |vec_i;
  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = vec_i & (~vec_i + DEF_NUM_IR'(1));

endmodule

// File: rtl/inta_sequencer.sv
// 8259 INT/INTA responder owning the ISR; 8086-mode two-pulse acknowledge.
// Build option: define INTA_AUTO_EOI_EN to clear the ISR bit at the end of the second INTA pulse.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int NUM_IR      = DEF_NUM_IR,
  parameter int SPURIOUS_IR = DEF_SPURIOUS_IR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] maskedRequest,
  input  logic [4:0]        vectorBase,
  input  logic              intaN,
  input  logic              eoi,
  output logic              intOut,
  output logic [NUM_IR-1:0] irrClear,
  output logic [NUM_IR-1:0] isr,
  output logic [7:0]        dataOut,
  output logic              dataOutEn
);

  state_e                state_q, state_d;
  logic                  intaPrev_q;
  logic                  intOut_q, intOut_d;
  logic [NUM_IR-1:0]     irrClear_q, irrClear_d;
  logic [NUM_IR-1:0]     isr_q, isr_d;
  logic [VEC_LO_W-1:0]   ackId_q, ackId_d;
  logic                  spurious_q, spurious_d;
  logic [7:0]            dataOut_q, dataOut_d;
  logic                  dataOutEn_q, dataOutEn_d;
  logic [NUM_IR-1:0]     setBit, clrBit;

  logic [VEC_LO_W-1:0]   reqIdx, svcIdx;
  logic                  reqValid, svcValid;
  logic [NUM_IR-1:0]     reqOneHot, svcOneHot;
  logic                  pending, fall, rise;

  pic_priority_encoder u_req_enc (
    .vec_i    (maskedRequest),
    .idx_o    (reqIdx),
    .valid_o  (reqValid),
    .onehot_o (reqOneHot)
  );

  pic_priority_encoder u_svc_enc (
    .vec_i    (isr_q),
    .idx_o    (svcIdx),
    .valid_o  (svcValid),
    .onehot_o (svcOneHot)
  );

  assign fall    = intaPrev_q & ~intaN;
  assign rise    = ~intaPrev_q & intaN;
  assign pending = reqValid & (~svcValid | (reqIdx < svcIdx));

  always_comb begin
    state_d     = state_q;
    ackId_d     = ackId_q;
    spurious_d  = spurious_q;
    irrClear_d  = '0;
    dataOut_d   = dataOut_q;
    dataOutEn_d = dataOutEn_q;
    setBit      = '0;
    clrBit      = eoi ? svcOneHot : '0;
    case (state_q)
      ST_IDLE: if (pending) state_d = ST_REQ;
      ST_REQ: begin
        // A falling edge wins over a vanishing request: that is the spurious case.
        if (fall) begin
          state_d = ST_ACK1;
          if (pending) begin
            ackId_d    = reqIdx;
            spurious_d = 1'b0;
            setBit     = reqOneHot;
            irrClear_d = reqOneHot;
          end else begin
            ackId_d    = SPURIOUS_IR[VEC_LO_W-1:0];
            spurious_d = 1'b1;
          end
        end else if (!pending) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK1: if (rise) state_d = ST_GAP;
      ST_GAP: begin
        if (fall) begin
          state_d     = ST_ACK2;
          dataOut_d   = {vectorBase, ackId_q};
          dataOutEn_d = 1'b1;
        end
      end
      ST_ACK2: begin
        if (rise) begin
          state_d     = ST_IDLE;
          dataOut_d   = '0;
          dataOutEn_d = 1'b0;
`ifdef INTA_AUTO_EOI_EN
          if (!spurious_q) clrBit = clrBit | (NUM_IR'(1) << ackId_q);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    isr_d    = (isr_q & ~clrBit) | setBit;
    intOut_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      intaPrev_q  <= 1'b1;
      intOut_q    <= 1'b0;
      irrClear_q  <= '0;
      isr_q       <= '0;
      ackId_q     <= '0;
      spurious_q  <= 1'b0;
      dataOut_q   <= '0;
      dataOutEn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      intaPrev_q  <= intaN;
      intOut_q    <= intOut_d;
      irrClear_q  <= irrClear_d;
      isr_q       <= isr_d;
      ackId_q     <= ackId_d;
      spurious_q  <= spurious_d;
      dataOut_q   <= dataOut_d;
      dataOutEn_q <= dataOutEn_d;
    end
  end

  assign intOut    = intOut_q;
  assign irrClear  = irrClear_q;
  assign isr       = isr_q;
  assign dataOut   = dataOut_q;
  assign dataOutEn = dataOutEn_q;

endmodule
